// File: rtl/pwm_button_multi_if.sv
// Pin-side bundle for pwm_button_multi: control and button inputs in, PWM and status out.
// The master drives the buttons and control lines; the slave is the PWM tile itself.
interface pwm_button_multi_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                en;
  logic                btn_up;
  logic                btn_down;
  logic                btn_clr;
  logic [SELW-1:0]     sel;
  logic [CHANNELS-1:0] pwm_out;
  logic [WIDTH-1:0]    duty_sel;
  logic                period_msb;

  modport master (
    output en, btn_up, btn_down, btn_clr, sel,
    input  pwm_out, duty_sel, period_msb
  );

  modport slave (
    input  en, btn_up, btn_down, btn_clr, sel,
    output pwm_out, duty_sel, period_msb
  );
endinterface

// File: rtl/pwm_button_multi.sv
// Multi-channel PWM generator with debounced up/down/clear buttons editing the selected channel.
// Edits land in a pending register and are copied to the active duty at each period boundary.
module pwm_button_multi #(
  parameter int WIDTH    = 4,
  parameter int DEB_LEN  = 7,
  parameter int CHANNELS = 2,
  parameter int WRAP     = 0,
  parameter int INVERT   = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  pwm_button_multi_if.slave  bus
);
  localparam int               SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] DMAX    = '1;
  localparam logic             INV_BIT = (INVERT != 0);
  localparam logic             WRAP_ON = (WRAP != 0);

  // Button index: 0 = up, 1 = down, 2 = clear
  logic [2:0]         w_raw;
  logic [2:0]         w_level;
  logic [2:0]         w_press;
  logic [DEB_LEN-1:0] r_sr [3];
  logic [2:0]         r_lvl;

  logic [WIDTH-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_pend [CHANNELS];
  logic [WIDTH-1:0]    r_act  [CHANNELS];
  logic [CHANNELS-1:0] r_pwm;

  logic             w_sel_ok;
  logic [WIDTH-1:0] w_sel_duty;
  logic [WIDTH-1:0] w_next;
  logic             w_apply;
  logic             w_boundary;

  assign w_raw = {bus.btn_clr, bus.btn_down, bus.btn_up};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < 3; b++) r_sr[b] <= '0;
      r_lvl <= '0;
    end else begin
      for (int b = 0; b < 3; b++) r_sr[b] <= {r_sr[b][DEB_LEN-2:0], w_raw[b]};
      r_lvl <= w_level;
    end
  end

  always_comb begin
    w_level = '0;
    for (int b = 0; b < 3; b++) w_level[b] = &r_sr[b];
  end

  assign w_press = w_level & ~r_lvl;

  // Out-of-range selects read back as 0 and swallow any press
  assign w_sel_ok = (int'(bus.sel) < CHANNELS);

  always_comb begin
    w_sel_duty = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (c == int'(bus.sel)) w_sel_duty = r_pend[c];
    end
  end

  always_comb begin
    w_next = w_sel_duty;
    if (w_press[2]) begin
      w_next = '0;
    end else if (w_press[0] && w_press[1]) begin
      w_next = w_sel_duty;
    end else if (w_press[0]) begin
      if (w_sel_duty == DMAX) w_next = WRAP_ON ? '0 : DMAX;
      else                    w_next = w_sel_duty + WIDTH'(1);
    end else if (w_press[1]) begin
      if (w_sel_duty == '0) w_next = WRAP_ON ? DMAX : '0;
      else                  w_next = w_sel_duty - WIDTH'(1);
    end
  end

  assign w_apply    = (|w_press) && w_sel_ok;
  assign w_boundary = bus.en && (r_cnt == DMAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < CHANNELS; c++) r_pend[c] <= '0;
    end else if (w_apply) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (c == int'(bus.sel)) r_pend[c] <= w_next;
      end
    end
  end

  // The commit samples pending before this edge's press, so a coincident press waits a period
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_pwm <= '0;
      for (int c = 0; c < CHANNELS; c++) r_act[c] <= '0;
    end else if (bus.en) begin
      r_cnt <= r_cnt + WIDTH'(1);
      for (int c = 0; c < CHANNELS; c++) r_pwm[c] <= (r_cnt < r_act[c]);
      if (w_boundary) begin
        for (int c = 0; c < CHANNELS; c++) r_act[c] <= r_pend[c];
      end
    end
  end

  assign bus.pwm_out    = r_pwm ^ {CHANNELS{INV_BIT}};
  assign bus.duty_sel   = w_sel_duty;
  assign bus.period_msb = r_cnt[WIDTH-1];
endmodule

// File: tb/tb_pwm_button_multi.sv
// Randomised bench: two differently-parameterised instances share button stimulus and are
// compared every cycle against a run-length/arithmetic reference model.
module tb_pwm_button_multi;
  logic clk;
  logic rst;

  pwm_button_multi_if #(.WIDTH(4), .CHANNELS(2)) busA ();
  pwm_button_multi_if #(.WIDTH(3), .CHANNELS(3)) busB ();

  pwm_button_multi #(.WIDTH(4), .DEB_LEN(7), .CHANNELS(2), .WRAP(0), .INVERT(0)) dutA (
    .i_clk(clk), .i_rst(rst), .bus(busA.slave)
  );
  pwm_button_multi #(.WIDTH(3), .DEB_LEN(3), .CHANNELS(3), .WRAP(1), .INVERT(1)) dutB (
    .i_clk(clk), .i_rst(rst), .bus(busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  bit rstIn, enIn, upIn, downIn, clrIn;
  int selIn [2];

  int runLen  [2][3];
  bit lvlPrev [2][3];
  int pend    [2][8];
  int act     [2][8];
  bit pwmQ    [2][8];
  int cnt     [2];

  function automatic int cfgW(int d);   return (d == 0) ? 4 : 3; endfunction
  function automatic int cfgDeb(int d); return (d == 0) ? 7 : 3; endfunction
  function automatic int cfgCh(int d);  return (d == 0) ? 2 : 3; endfunction
  function automatic bit cfgWrap(int d); return d == 1; endfunction
  function automatic bit cfgInv(int d);  return d == 1; endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset(input int d);
    for (int b = 0; b < 3; b++) begin runLen[d][b] = 0; lvlPrev[d][b] = 1'b0; end
    for (int c = 0; c < 8; c++) begin pend[d][c] = 0; act[d][c] = 0; pwmQ[d][c] = 1'b0; end
    cnt[d] = 0;
  endtask

  // One rising edge of the reference model for instance d, using the applied inputs
  task automatic modelStep(input int d);
    int  period, mx, s;
    bit  raw   [3];
    bit  press [3];
    int  snap  [8];
    if (rstIn) begin
      modelReset(d);
      return;
    end
    period = 1 << cfgW(d);
    mx     = period - 1;
    raw[0] = upIn; raw[1] = downIn; raw[2] = clrIn;
    for (int b = 0; b < 3; b++) begin
      press[b]      = (runLen[d][b] >= cfgDeb(d)) && !lvlPrev[d][b];
      lvlPrev[d][b] = (runLen[d][b] >= cfgDeb(d));
      runLen[d][b]  = raw[b] ? ((runLen[d][b] < 1000) ? runLen[d][b] + 1 : 1000) : 0;
    end
    for (int c = 0; c < 8; c++) snap[c] = pend[d][c];
    if (enIn) begin
      for (int c = 0; c < cfgCh(d); c++) pwmQ[d][c] = (cnt[d] < act[d][c]);
      if (cnt[d] == mx) for (int c = 0; c < 8; c++) act[d][c] = snap[c];
      cnt[d] = (cnt[d] + 1) % period;
    end
    s = selIn[d];
    if ((press[0] || press[1] || press[2]) && s < cfgCh(d)) begin
      if (press[2])                pend[d][s] = 0;
      else if (press[0] && press[1]) pend[d][s] = pend[d][s];
      else if (press[0])           pend[d][s] = cfgWrap(d) ? (pend[d][s] + 1) % period
                                                         : ((pend[d][s] + 1 > mx) ? mx : pend[d][s] + 1);
      else                         pend[d][s] = cfgWrap(d) ? (pend[d][s] - 1 + period) % period
                                                         : ((pend[d][s] == 0) ? 0 : pend[d][s] - 1);
    end
  endtask

  function automatic int expPwm(input int d);
    int v = 0;
    for (int c = 0; c < cfgCh(d); c++) v |= int'(pwmQ[d][c] ^ cfgInv(d)) << c;
    return v;
  endfunction

  function automatic int expDuty(input int d);
    return (selIn[d] < cfgCh(d)) ? pend[d][selIn[d]] : 0;
  endfunction

  task automatic checkAll();
    checkOutput("A.pwm_out",    int'(busA.pwm_out),    expPwm(0));
    checkOutput("A.duty_sel",   int'(busA.duty_sel),   expDuty(0));
    checkOutput("A.period_msb", int'(busA.period_msb), (cnt[0] >> 3) & 1);
    checkOutput("B.pwm_out",    int'(busB.pwm_out),    expPwm(1));
    checkOutput("B.duty_sel",   int'(busB.duty_sel),   expDuty(1));
    checkOutput("B.period_msb", int'(busB.period_msb), (cnt[1] >> 2) & 1);
  endtask

  // Drive one cycle of inputs at the falling edge, clock it, then compare at the next falling edge
  task automatic applyStimulus(input bit r, input bit e, input bit u, input bit dn,
                               input bit cl, input int s0, input int s1);
    rstIn = r; enIn = e; upIn = u; downIn = dn; clrIn = cl;
    selIn[0] = s0; selIn[1] = s1;
    rst = r;
    busA.en = e; busA.btn_up = u; busA.btn_down = dn; busA.btn_clr = cl; busA.sel = 1'(s0);
    busB.en = e; busB.btn_up = u; busB.btn_down = dn; busB.btn_clr = cl; busB.sel = 2'(s1);
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    @(negedge clk);
    checkAll();
  endtask

  task automatic holdButton(input bit u, input bit dn, input bit cl, input int len,
                            input int rel, input bit e, input int s0, input int s1);
    for (int i = 0; i < len; i++) applyStimulus(1'b0, e, u, dn, cl, s0, s1);
    for (int i = 0; i < rel; i++) applyStimulus(1'b0, e, 1'b0, 1'b0, 1'b0, s0, s1);
  endtask

  initial begin
    int act_sel, len, s0, s1;
    bit e;
    rst = 1'b1;
    modelReset(0);
    modelReset(1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    holdButton(1'b1, 1'b0, 1'b0, 6, 3, 1'b1, 0, 0);
    holdButton(1'b1, 1'b0, 1'b0, 20, 3, 1'b1, 0, 0);
    for (int i = 0; i < 18; i++) holdButton(1'b1, 1'b0, 1'b0, 9, 2, 1'b1, 1, 1);
    holdButton(1'b0, 1'b1, 1'b0, 9, 2, 1'b1, 1, 2);
    holdButton(1'b1, 1'b1, 1'b0, 10, 2, 1'b1, 1, 1);
    holdButton(1'b1, 1'b0, 1'b1, 10, 2, 1'b1, 1, 1);
    holdButton(1'b1, 1'b0, 1'b0, 10, 2, 1'b1, 0, 3);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

    for (int p = 0; p < 300; p++) begin
      act_sel = $urandom_range(0, 99);
      len     = $urandom_range(1, 12);
      e       = ($urandom_range(0, 9) != 0);
      s0      = $urandom_range(0, 1);
      s1      = $urandom_range(0, 3);
      if (act_sel < 3) begin
        for (int i = 0; i < $urandom_range(1, 3); i++)
          applyStimulus(1'b1, e, 1'(($urandom & 1)), 1'b0, 1'b0, s0, s1);
      end else if (act_sel < 43) begin
        holdButton(1'b1, 1'b0, 1'b0, len, $urandom_range(1, 4), e, s0, s1);
      end else if (act_sel < 68) begin
        holdButton(1'b0, 1'b1, 1'b0, len, $urandom_range(1, 4), e, s0, s1);
      end else if (act_sel < 73) begin
        holdButton(1'b0, 1'b0, 1'b1, len, $urandom_range(1, 4), e, s0, s1);
      end else if (act_sel < 78) begin
        holdButton(1'b1, 1'b1, 1'b0, len, $urandom_range(1, 4), e, s0, s1);
      end else if (act_sel < 83) begin
        holdButton(1'b1, 1'b0, 1'b1, len, $urandom_range(1, 4), e, s0, s1);
      end else begin
        holdButton(1'b0, 1'b0, 1'b0, len, 0, e, s0, s1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
